// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the immediate generator: result type codes,
// RV32/RV64 major opcodes and RVC quadrant / funct3 encodings.
package imm_gen_pipe_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    INST_I   = 3'd1,
    INST_S   = 3'd2,
    INST_B   = 3'd3,
    INST_U   = 3'd4,
    INST_J   = 3'd5
  } imm_type_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] RVC_Q0 = 2'b00;
  localparam logic [1:0] RVC_Q1 = 2'b01;
  localparam logic [1:0] RVC_Q2 = 2'b10;

  localparam logic [2:0] C_F3_ADDI = 3'b000;
  localparam logic [2:0] C_F3_LI   = 3'b010;
  localparam logic [2:0] C_F3_LUI  = 3'b011;
  localparam logic [2:0] C_F3_J    = 3'b101;
  localparam logic [2:0] C_F3_BEQZ = 3'b110;
  localparam logic [2:0] C_F3_BNEZ = 3'b111;
  localparam logic [2:0] C_F3_LW   = 3'b010;
  localparam logic [2:0] C_F3_SW   = 3'b110;

  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_imm_decode.sv
// Combinational immediate decode of one raw instruction word; classifies
// from the opcode (or RVC quadrant/funct3) and extends to XLEN.
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RVC_EN = 1
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_type_e       imm_type,
  output logic            is_rvc
);

  logic [6:0] opcode;
  logic [2:0] f3_32;
  logic [2:0] f3_c;
  logic [1:0] quad;

  assign opcode = inst[6:0];
  assign f3_32  = inst[14:12];
  assign f3_c   = inst[15:13];
  assign quad   = inst[1:0];
  assign is_rvc = (RVC_EN != 0) && (quad != 2'b11);

  always_comb begin
    imm      = '0;
    imm_type = IMM_NONE;
    if (!is_rvc) begin
      case (opcode)
        OP_LUI, OP_AUIPC: begin
          imm_type = INST_U;
          imm      = XLEN'($signed({inst[31:12], 12'b0}));
        end
        OP_JAL: begin
          imm_type = INST_J;
          imm      = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        end
        OP_JALR, OP_LOAD: begin
          imm_type = INST_I;
          imm      = XLEN'($signed(inst[31:20]));
        end
        OP_IMM: begin
          imm_type = INST_I;
          if (is_shift_f3(f3_32))
            imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
          else
            imm = XLEN'($signed(inst[31:20]));
        end
        OP_IMM32: begin
          // word ops only exist on RV64
          if (XLEN == 64) begin
            imm_type = INST_I;
            imm      = is_shift_f3(f3_32) ? XLEN'(inst[24:20]) : XLEN'($signed(inst[31:20]));
          end
        end
        OP_STORE: begin
          imm_type = INST_S;
          imm      = XLEN'($signed({inst[31:25], inst[11:7]}));
        end
        OP_BRANCH: begin
          imm_type = INST_B;
          imm      = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        end
        OP_SYSTEM: begin
          imm_type = INST_I;
          imm      = XLEN'(inst[31:20]);
        end
        default: ;
      endcase
    end else begin
      case (quad)
        RVC_Q1: begin
          case (f3_c)
            C_F3_ADDI, C_F3_LI: begin
              imm_type = INST_I;
              imm      = XLEN'($signed({inst[12], inst[6:2]}));
            end
            C_F3_LUI: begin
              if (inst[11:7] == 5'd2) begin
                imm_type = INST_I;
                imm      = XLEN'($signed({inst[12], inst[4:3], inst[5], inst[2], inst[6], 4'b0}));
              end else begin
                imm_type = INST_U;
                imm      = XLEN'($signed({inst[12], inst[6:2], 12'b0}));
              end
            end
            C_F3_J: begin
              imm_type = INST_J;
              imm      = XLEN'($signed({inst[12], inst[8], inst[10:9], inst[6], inst[7],
                                        inst[2], inst[11], inst[5:3], 1'b0}));
            end
            C_F3_BEQZ, C_F3_BNEZ: begin
              imm_type = INST_B;
              imm      = XLEN'($signed({inst[12], inst[6:5], inst[2], inst[11:10],
                                        inst[4:3], 1'b0}));
            end
            default: ;
          endcase
        end
        RVC_Q0: begin
          if (f3_c == C_F3_LW || f3_c == C_F3_SW) begin
            imm_type = (f3_c == C_F3_LW) ? INST_I : INST_S;
            imm      = XLEN'({inst[5], inst[12:10], inst[6], 2'b0});
          end
        end
        RVC_Q2: begin
          if (f3_c == C_F3_LW) begin
            imm_type = INST_I;
            imm      = XLEN'({inst[3:2], inst[12], inst[6:4], 2'b0});
          end else if (f3_c == C_F3_SW) begin
            imm_type = INST_S;
            imm      = XLEN'({inst[8:7], inst[12:9], 2'b0});
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Single registered stage around imm_decode with a valid/ready handshake and
// a one-entry skid register so a stalled consumer never costs throughput.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RVC_EN = 1,
  parameter int TAG_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output imm_type_e        out_type,
  output logic             out_is_rvc,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0]  dec_imm;
  imm_type_e        dec_type;
  logic             dec_rvc;

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  imm_type_e        skid_type;
  logic             skid_is_rvc;
  logic [TAG_W-1:0] skid_tag;

  logic accept;
  logic drain;

  imm_decode #(
    .XLEN   (XLEN),
    .RVC_EN (RVC_EN)
  ) u_decode (
    .inst     (in_inst),
    .imm      (dec_imm),
    .imm_type (dec_type),
    .is_rvc   (dec_rvc)
  );

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_type    <= IMM_NONE;
      out_is_rvc  <= 1'b0;
      out_tag     <= '0;
      skid_valid  <= 1'b0;
      skid_imm    <= '0;
      skid_type   <= IMM_NONE;
      skid_is_rvc <= 1'b0;
      skid_tag    <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain || !out_valid) begin
      // skid is older than anything arriving, so it always goes first
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_imm    <= skid_imm;
        out_type   <= skid_type;
        out_is_rvc <= skid_is_rvc;
        out_tag    <= skid_tag;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid  <= 1'b1;
        out_imm    <= dec_imm;
        out_type   <= dec_type;
        out_is_rvc <= dec_rvc;
        out_tag    <= in_tag;
      end else begin
        out_valid  <= 1'b0;
      end
    end else if (accept) begin
      skid_valid  <= 1'b1;
      skid_imm    <= dec_imm;
      skid_type   <= dec_type;
      skid_is_rvc <= dec_rvc;
      skid_tag    <= in_tag;
    end
  end

endmodule
